// File: rtl/gpu_instruction_dispatcher.sv
// gpu_instruction_dispatcher
//   Fetches one instruction at a time from a show-ahead FIFO.
//   Registers the instruction's operands.
//   Pulses the start strobe of the matching drawing unit.
//   Waits for that unit's done pulse before fetching again, so drawing
//   stays strictly in order.
//
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   fifo_empty_i         FIFO empty flag
//   opcode_i, *_i        FIFO head opcode and operand fields
//   pop_instruction_o    one-cycle FIFO pop
//   halt_i               inhibit new fetches (in-flight work completes)
//   clr_err_i            clear sticky illegal-opcode flag
//   unit_done_i[3:0]     done pulses: [0]=clear [1]=rect [2]=line [3]=arc
//   start_o[3:0]         one-cycle start strobes, same mapping
//   *_o                  registered operands
//   busy_o               instruction in flight
//   err_opcode_o         sticky illegal-opcode flag
//   retired_cnt_o        retired instruction count
//
// Build option: GPU_DISPATCH_PERF_EN enables the retired-instruction
// counter. When it is undefined, retired_cnt_o is tied to 0.
module gpu_instruction_dispatcher #(
    parameter int WIDTH_BITS   = 10,
    parameter int HEIGHT_BITS  = 9,
    parameter int CHANNEL_BITS = 8
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    fifo_empty_i,
    input  logic [3:0]              opcode_i,
    input  logic [WIDTH_BITS-1:0]   x1_i,
    input  logic [HEIGHT_BITS-1:0]  y1_i,
    input  logic [WIDTH_BITS-1:0]   x2_i,
    input  logic [HEIGHT_BITS-1:0]  y2_i,
    input  logic [WIDTH_BITS-1:0]   rad_i,
    input  logic [CHANNEL_BITS-1:0] r_i,
    input  logic [CHANNEL_BITS-1:0] g_i,
    input  logic [CHANNEL_BITS-1:0] b_i,
    input  logic [2:0]              quad_i,
    output logic                    pop_instruction_o,
    input  logic                    halt_i,
    input  logic                    clr_err_i,
    input  logic [3:0]              unit_done_i,
    output logic [3:0]              start_o,
    output logic [WIDTH_BITS-1:0]   x1_o,
    output logic [HEIGHT_BITS-1:0]  y1_o,
    output logic [WIDTH_BITS-1:0]   x2_o,
    output logic [HEIGHT_BITS-1:0]  y2_o,
    output logic [WIDTH_BITS-1:0]   rad_o,
    output logic [CHANNEL_BITS-1:0] r_o,
    output logic [CHANNEL_BITS-1:0] g_o,
    output logic [CHANNEL_BITS-1:0] b_o,
    output logic [2:0]              quad_o,
    output logic                    busy_o,
    output logic                    err_opcode_o,
    output logic [15:0]             retired_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              opcode_q, opcode_d;
    logic [WIDTH_BITS-1:0]   x1_q, x1_d, x2_q, x2_d, rad_q, rad_d;
    logic [HEIGHT_BITS-1:0]  y1_q, y1_d, y2_q, y2_d;
    logic [CHANNEL_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [2:0]              quad_q, quad_d;
    logic                    err_q, err_d;
    logic                    pop;
    logic                    done_hit;

    // One-hot unit select. NOP and illegal opcodes select no unit.
    function automatic logic [3:0] unit_mask(input logic [3:0] op);
        case (op)
            4'd1:    unit_mask = 4'b0001;
            4'd2:    unit_mask = 4'b0010;
            4'd3:    unit_mask = 4'b0100;
            4'd4:    unit_mask = 4'b1000;
            default: unit_mask = 4'b0000;
        endcase
    endfunction

    assign done_hit = |(unit_done_i & unit_mask(opcode_q));

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        x2_d     = x2_q;
        y2_d     = y2_q;
        rad_d    = rad_q;
        r_d      = r_q;
        g_d      = g_q;
        b_d      = b_q;
        quad_d   = quad_q;
        pop      = 1'b0;
        start_o  = '0;
        // The clear is applied first so that a new illegal opcode in the
        // same cycle sets the flag again.
        err_d    = clr_err_i ? 1'b0 : err_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty_i && !halt_i) begin
                    pop      = 1'b1;
                    opcode_d = opcode_i;
                    x1_d     = x1_i;
                    y1_d     = y1_i;
                    x2_d     = x2_i;
                    y2_d     = y2_i;
                    rad_d    = rad_i;
                    r_d      = r_i;
                    g_d      = g_i;
                    b_d      = b_i;
                    quad_d   = quad_i;
                    if (unit_mask(opcode_i) != 4'b0000) begin
                        state_d = S_ISSUE;
                    end
                    if (opcode_i > 4'd4) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                start_o = unit_mask(opcode_q);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            x2_q     <= '0;
            y2_q     <= '0;
            rad_q    <= '0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            quad_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            x2_q     <= x2_d;
            y2_q     <= y2_d;
            rad_q    <= rad_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            quad_q   <= quad_d;
            err_q    <= err_d;
        end
    end

    // The pop is derived from live FIFO inputs, so it is gated by reset.
    // This keeps the FIFO from being popped while nrst is low.
    assign pop_instruction_o = pop & nrst;
    assign busy_o            = (state_q != S_IDLE);
    assign err_opcode_o      = err_q;
    assign x1_o              = x1_q;
    assign y1_o              = y1_q;
    assign x2_o              = x2_q;
    assign y2_o              = y2_q;
    assign rad_o             = rad_q;
    assign r_o               = r_q;
    assign g_o               = g_q;
    assign b_o               = b_q;
    assign quad_o            = quad_q;

`ifdef GPU_DISPATCH_PERF_EN
    logic [15:0] cnt_q, cnt_d;
    logic        retire;

    // Completed drawing instructions and popped NOPs retire.
    // Illegal opcodes do not retire.
    assign retire = (state_q == S_WAIT && done_hit) ||
                    (pop && opcode_i == 4'd0);

    always_comb begin
        cnt_d = cnt_q;
        if (retire) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retired_cnt_o = cnt_q;
`else
    assign retired_cnt_o = '0;
`endif

endmodule
